fifo_write_arbiter: RTL

- Write-domain controller for the dual-clock FIFO storage array.
- Shares the single memory write port among NREQ requesters with round-robin arbitration, one write per w_clk.
- Generates the write address, binary and Gray write pointers, and the registered full flag.
- Synchronises the read-domain Gray pointer into w_clk with a two-flop synchroniser.

---
 rtl/fifo_write_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/fifo_write_arbiter.sv
// Write-domain side of the dual-clock FIFO: round-robin write-port arbiter, binary/Gray
// write pointers, two-flop synchroniser for the read pointer and the registered full flag.
module fifo_write_arbiter #(
  parameter int WIDTH = 4,
  parameter int ADDR  = 2,
  parameter int NREQ  = 4
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       grant,
  output logic                  mem_w_en,
  output logic [ADDR-1:0]       mem_w_addr,
  output logic [WIDTH-1:0]      mem_w_data,
  output logic                  full,
  output logic [ADDR:0]         w_ptr_gray,
  input  logic [ADDR:0]         r_ptr_gray_async
);

  localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [RRW-1:0]   rr_q, rr_d;
  logic [ADDR:0]    wbin_q, wbin_d;
  logic [ADDR:0]    wgray_q, wgray_d;
  logic [ADDR:0]    rq1_q, rq2_q;
  logic             full_q, full_d;
  logic [NREQ-1:0]  grant_c;
  logic [RRW-1:0]   sel;
  logic [RRW-1:0]   idx;
  logic             found;
  logic [WIDTH-1:0] data_c;

  // Scan rr, rr+1, ... wrapping at NREQ; grant is forced low while reset is held.
  always_comb begin
    grant_c = '0;
    sel     = '0;
    found   = 1'b0;
    idx     = rr_q;
    if (!w_rst && !full_q) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && req[idx]) begin
          found        = 1'b1;
          grant_c[idx] = 1'b1;
          sel          = idx;
        end
        idx = (idx == RRW'(NREQ - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  always_comb begin
    data_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_c[i]) data_c = data_c | req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    rr_d    = rr_q;
    if (found) rr_d = (sel == RRW'(NREQ - 1)) ? '0 : sel + 1'b1;
    wbin_d  = wbin_q + {{ADDR{1'b0}}, found};
    wgray_d = wbin_d ^ (wbin_d >> 1);
    // Full when the next write pointer is one lap ahead of the synchronised read pointer.
    full_d  = (wgray_d == {~rq2_q[ADDR:ADDR-1], rq2_q[ADDR-2:0]});
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      rr_q    <= '0;
      wbin_q  <= '0;
      wgray_q <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      rr_q    <= rr_d;
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rq1_q   <= r_ptr_gray_async;
      rq2_q   <= rq1_q;
      full_q  <= full_d;
    end
  end

  assign grant      = grant_c;
  assign mem_w_en   = found;
  assign mem_w_addr = wbin_q[ADDR-1:0];
  assign mem_w_data = data_c;
  assign full       = full_q;
  assign w_ptr_gray = wgray_q;

endmodule
